// File: rtl/nmid_dispatch_merge.sv
// NMID dispatcher/merger: steers LMID packets to the function module and merges
// bypass and returned packets onto one egress port with whole-packet admission.
module nmid_dispatch_merge #(
  parameter int LMID       = 7,
  parameter int W_PKT      = 134,
  parameter int BITMAP_LSB = 26,
  parameter int DEPTH_LOG2 = 8,
  parameter int MAX_PKT    = 32,
  parameter int ARB_MODE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_wr,
  input  logic [W_PKT-1:0] in_data,
  input  logic             ret_wr,
  input  logic [W_PKT-1:0] ret_data,
  output logic             fm_wr,
  output logic [W_PKT-1:0] fm_data,
  output logic             out_wr,
  output logic [W_PKT-1:0] out_data,
  input  logic             out_ready,
  output logic [31:0]      cnt_fm,
  output logic [31:0]      cnt_byp,
  output logic [31:0]      cnt_drop
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {S_IDLE, S_SEND} state_t;
  state_t r_state, w_state_nxt;

  logic             r_fm_pkt, r_fm_wr, r_gnt, w_gnt_nxt, w_pop;
  logic [W_PKT-1:0] r_fm_data, r_out_last, w_src, w_out_data;
  logic [31:0]      r_cnt_fm, r_cnt_byp, r_cnt_drop;
  logic [32:0]      w_drop_sum;
  logic             w_in_head, w_in_tail, w_bit, w_to_fm;

  // Path index 0 = bypass, 1 = return
  logic [1:0]            w_wr, w_ne, w_hd, w_fit, w_drop, w_pop_v;
  logic [1:0][W_PKT-1:0] w_din, w_hdata;

  assign w_in_head = in_wr && (in_data[W_PKT-1 -: 2] == 2'b01);
  assign w_in_tail = in_wr && (in_data[W_PKT-1 -: 2] == 2'b10);
  assign w_bit     = in_data[BITMAP_LSB+LMID];
  // Non-head beats follow the class of the packet in progress; orphans fall to the
  // bypass path, which discards them because no packet is open there.
  assign w_to_fm   = in_wr && (w_in_head ? w_bit : r_fm_pkt);

  assign w_wr  = {ret_wr, in_wr && !w_to_fm};
  assign w_din = {ret_data, in_data};

  for (genvar p = 0; p < 2; p++) begin : g_path
    logic                  r_wr, r_acc, w_head, w_tail, w_we, w_re;
    logic [W_PKT-1:0]      r_data;
    logic [W_PKT-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp, r_rp;
    logic [DEPTH_LOG2:0]   r_cnt, w_free;

    assign w_head = r_wr && (r_data[W_PKT-1 -: 2] == 2'b01);
    assign w_tail = r_wr && (r_data[W_PKT-1 -: 2] == 2'b10);
    assign w_free = (DEPTH_LOG2+1)'(DEPTH) - r_cnt;
    assign w_fit[p] = 32'(w_free) >= 32'(MAX_PKT);
    assign w_hd[p]  = w_head;
    assign w_we = r_wr && (w_head ? w_fit[p] : r_acc) && !r_cnt[DEPTH_LOG2];
    assign w_re = w_pop_v[p] && w_ne[p];
    assign w_ne[p]    = (r_cnt != '0);
    assign w_hdata[p] = r_mem[r_rp];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wr   <= 1'b0;
        r_data <= '0;
        r_acc  <= 1'b0;
        r_wp   <= '0;
        r_rp   <= '0;
        r_cnt  <= '0;
      end else begin
        r_wr <= w_wr[p];
        if (w_wr[p]) r_data <= w_din[p];
        if (w_head)      r_acc <= w_fit[p];
        else if (w_tail) r_acc <= 1'b0;
        if (w_we) r_wp <= r_wp + DEPTH_LOG2'(1);
        if (w_re) r_rp <= r_rp + DEPTH_LOG2'(1);
        r_cnt <= r_cnt + (DEPTH_LOG2+1)'(w_we) - (DEPTH_LOG2+1)'(w_re);
      end
    end

    always_ff @(posedge clk) begin
      if (w_we) r_mem[r_wp] <= r_data;
    end
  end

  assign w_drop     = w_hd & ~w_fit;
  assign w_drop_sum = {1'b0, r_cnt_drop} + 33'(w_drop[0]) + 33'(w_drop[1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fm_wr    <= 1'b0;
      r_fm_data  <= '0;
      r_fm_pkt   <= 1'b0;
      r_out_last <= '0;
      r_cnt_fm   <= '0;
      r_cnt_byp  <= '0;
      r_cnt_drop <= '0;
    end else begin
      r_fm_wr <= w_to_fm;
      if (w_to_fm) r_fm_data <= in_data;
      if (w_in_head)      r_fm_pkt <= w_bit;
      else if (w_in_tail) r_fm_pkt <= 1'b0;
      if (w_pop) r_out_last <= w_src;
      if (w_in_head && w_bit && !(&r_cnt_fm)) r_cnt_fm <= r_cnt_fm + 32'd1;
      if (w_hd[0] && w_fit[0] && !(&r_cnt_byp)) r_cnt_byp <= r_cnt_byp + 32'd1;
      r_cnt_drop <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
    end
  end

  // r_gnt doubles as the round-robin pointer: it holds the last granted path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      S_IDLE: if (|w_ne) begin
        w_state_nxt = S_SEND;
        if (ARB_MODE == 0) w_gnt_nxt = !w_ne[0];
        else               w_gnt_nxt = w_ne[!r_gnt] ? !r_gnt : r_gnt;
      end
      S_SEND: if (w_pop && (w_src[W_PKT-1 -: 2] == 2'b10)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_src      = w_hdata[r_gnt];
    w_pop      = (r_state == S_SEND) && out_ready && w_ne[r_gnt];
    w_pop_v    = {w_pop && r_gnt, w_pop && !r_gnt};
    w_out_data = w_pop ? w_src : r_out_last;
  end

  assign fm_wr    = r_fm_wr;
  assign fm_data  = r_fm_data;
  assign out_wr   = w_pop;
  assign out_data = w_out_data;
  assign cnt_fm   = r_cnt_fm;
  assign cnt_byp  = r_cnt_byp;
  assign cnt_drop = r_cnt_drop;
endmodule

// File: tb/tb_nmid_dispatch_merge.sv
// Scoreboard bench for nmid_dispatch_merge (round-robin, 32-entry FIFOs, MAX_PKT 8).
module tb_nmid_dispatch_merge;
  localparam int W = 134;

  logic         clk = 1'b0, reset = 1'b0;
  logic         in_wr = 1'b0, ret_wr = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0, ret_data = '0;
  logic         fm_wr, out_wr;
  logic [W-1:0] fm_data, out_data;
  logic [31:0]  cnt_fm, cnt_byp, cnt_drop;

  nmid_dispatch_merge #(.LMID(7), .W_PKT(W), .BITMAP_LSB(26), .DEPTH_LOG2(5),
                        .MAX_PKT(8), .ARB_MODE(1)) dut (
    .clk(clk), .reset(reset), .in_wr(in_wr), .in_data(in_data),
    .ret_wr(ret_wr), .ret_data(ret_data), .fm_wr(fm_wr), .fm_data(fm_data),
    .out_wr(out_wr), .out_data(out_data), .out_ready(out_ready),
    .cnt_fm(cnt_fm), .cnt_byp(cnt_byp), .cnt_drop(cnt_drop));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [W-1:0] d; int ts; } exp_t;
  exp_t q_out[$], q_fm[$];
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] last_exp = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] tg, input logic fm, input int seed);
    logic [W-1:0] d;
    logic [31:0]  s;
    s = 32'(seed);
    d = {tg, 4'h0, s, ~s, s ^ 32'hA5A5_A5A5, s + 32'd1};
    d[33] = (tg == 2'b01) ? fm : ~fm;  // body bit 33 must not affect routing
    return d;
  endfunction

  function automatic logic [1:0] tag_of(input int i, input int n);
    return (i == 0) ? 2'b01 : (i == n-1) ? 2'b10 : 2'b00;
  endfunction

  // Monitor: pops the scoreboard on every egress / FM beat
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("rst_out_wr", W'(out_wr), '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_fm_wr", W'(fm_wr), '0);
      chk("rst_fm_data", fm_data, '0);
      chk("rst_cnt_fm", W'(cnt_fm), '0);
      chk("rst_cnt_byp", W'(cnt_byp), '0);
      chk("rst_cnt_drop", W'(cnt_drop), '0);
    end else begin
      if (out_wr) begin
        chk("out_gate", W'(out_ready), W'(1));
        if (q_out.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_unexpected: got %h want no beat (cycle %0d)", out_data, cyc);
        end else begin
          e = q_out.pop_front();
          chk("out_data", out_data, e.d);
          if (e.ts >= 0) chk("out_cycle", W'(cyc), W'(e.ts));
          last_exp = e.d;
        end
      end else begin
        chk("out_hold", out_data, last_exp);
      end
      if (fm_wr) begin
        if (q_fm.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL fm_unexpected: got %h want no beat (cycle %0d)", fm_data, cyc);
        end else begin
          e = q_fm.pop_front();
          chk("fm_data", fm_data, e.d);
          chk("fm_cycle", W'(cyc), W'(e.ts));
        end
      end
    end
  end

  task automatic send(input int n, input logic fm, input int seed, input bit timed, input bit exp_out);
    int t0 = 0;
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] d;
      d = mk(tag_of(i, n), fm, seed + i);
      @(posedge clk); #1;
      if (i == 0) t0 = cyc;
      in_wr = 1'b1; in_data = d;
      if (fm) q_fm.push_back('{d, cyc + 1});
      else if (exp_out) q_out.push_back('{d, timed ? t0 + 3 + i : -1});
    end
    @(posedge clk); #1; in_wr = 1'b0;
  endtask

  task automatic send_ret(input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ret_wr = 1'b1; ret_data = mk(tag_of(i, n), 1'b0, seed + i);
    end
    @(posedge clk); #1; ret_wr = 1'b0;
  endtask

  task automatic drain(input int max);
    int k = 0;
    while ((q_out.size() != 0 || q_fm.size() != 0) && k < max) begin
      @(posedge clk); k++;
    end
    if (q_out.size() != 0 || q_fm.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d beats outstanding want 0", q_out.size() + q_fm.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; q_out.delete(); q_fm.delete(); last_exp = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] bd[4], rd[4];
    int r;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // FM packet: registered straight through, nothing on egress
    send(4, 1'b1, 100, 1'b0, 1'b0);
    drain(50);
    chk("t1_cnt_fm", W'(cnt_fm), W'(1));
    chk("t1_cnt_byp", W'(cnt_byp), '0);

    // Bypass packet, minimum latency 3
    out_ready = 1'b1;
    send(3, 1'b0, 200, 1'b1, 1'b1);
    drain(50);
    chk("t2_cnt_byp", W'(cnt_byp), W'(1));
    chk("t2_cnt_fm", W'(cnt_fm), W'(1));

    // Round-robin tie after reset: bypass first, then alternate
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bd[k] = mk(tag_of(k % 2, 2), 1'b0, 300 + k);
      rd[k] = mk(tag_of(k % 2, 2), 1'b0, 400 + k);
      @(posedge clk); #1;
      in_wr = 1'b1; in_data = bd[k]; ret_wr = 1'b1; ret_data = rd[k];
    end
    @(posedge clk); #1; in_wr = 1'b0; ret_wr = 1'b0;
    repeat (5) @(posedge clk);
    #1 r = cyc;
    q_out.push_back('{bd[0], r});     q_out.push_back('{bd[1], r + 1});
    q_out.push_back('{rd[0], r + 3}); q_out.push_back('{rd[1], r + 4});
    q_out.push_back('{bd[2], r + 6}); q_out.push_back('{bd[3], r + 7});
    q_out.push_back('{rd[2], r + 9}); q_out.push_back('{rd[3], r + 10});
    out_ready = 1'b1;
    drain(60);
    chk("t3_cnt_byp", W'(cnt_byp), W'(2));
    chk("t3_cnt_drop", W'(cnt_drop), '0);

    // Admission: 4 x 8 beats fill the 32-entry FIFO exactly, the 5th is dropped
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(8, 1'b0, 500 + k * 16, 1'b0, k < 4);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_cnt_byp", W'(cnt_byp), W'(6));
    chk("t4_cnt_drop", W'(cnt_drop), W'(1));
    out_ready = 1'b1;
    drain(200);

    // out_ready toggling; a return packet arriving mid-packet must wait
    for (int i = 0; i < 6; i++) q_out.push_back('{mk(tag_of(i, 6), 1'b0, 700 + i), -1});
    for (int i = 0; i < 2; i++) q_out.push_back('{mk(tag_of(i, 2), 1'b0, 800 + i), -1});
    out_ready = 1'b0;
    fork
      send(6, 1'b0, 700, 1'b0, 1'b0);
      begin @(posedge clk); send_ret(2, 800); end
      for (int i = 0; i < 40; i++) begin @(posedge clk); #1 out_ready = ~out_ready; end
    join
    out_ready = 1'b1;
    drain(100);
    chk("t5_cnt_byp", W'(cnt_byp), W'(7));

    // Reset mid-packet, orphan tail afterwards, then a clean packet
    @(posedge clk); #1 in_wr = 1'b1; in_data = mk(2'b01, 1'b0, 900);
    @(posedge clk); #1 in_data = mk(2'b00, 1'b0, 901);
    @(posedge clk); #1 in_data = mk(2'b00, 1'b0, 902);
    reset = 1'b0; q_out.delete(); q_fm.delete(); last_exp = '0;
    @(posedge clk); #1 in_wr = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 in_wr = 1'b1; in_data = mk(2'b10, 1'b1, 903);
    @(posedge clk); #1 in_wr = 1'b0;
    send(3, 1'b0, 950, 1'b1, 1'b1);
    drain(50);
    chk("t6_cnt_byp", W'(cnt_byp), W'(1));
    chk("t6_cnt_drop", W'(cnt_drop), '0);
    chk("t6_cnt_fm", W'(cnt_fm), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
